cover_toggle_drain_sched: RTL

Scheduler that sits beside a toggle-coverage point group. It turns a wide per-cycle hit vector into a serialized stream of first-time-hit cover indices, at most one per cycle, over a valid/ready handshake. Formal and fuzzing harnesses consume that stream instead of per-bit callbacks. It also keeps a sticky covered bitmap and a distinct-hit counter.

---
 rtl/cover_pkg.sv | 24 ++
 rtl/cover_lsb_pick.sv | 29 ++
 rtl/cover_toggle_drain_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/cover_pkg.sv
// Shared definitions for the toggle-coverage drain scheduler family:
// global cover-point total, the cover index type, the output slot states
// and the global index helper.
package cover_pkg;

    // Total number of cover points across every group in the design.
    localparam int COVER_TOTAL = 11747;

    // Global cover index as carried to the consumer.
    typedef logic [63:0] cover_idx_t;

    // Output slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Global index of a point: group base plus the bit position in the group.
    function automatic cover_idx_t cover_index_calc(input cover_idx_t base,
                                                    input cover_idx_t pos);
        return base + pos;
    endfunction

endpackage

// File: rtl/cover_lsb_pick.sv
// Lowest-set-bit finder over a WIDTH-bit vector. Purely combinational and
// parameterised so that coverage groups of any width can reuse it.
// Returns a found flag, the binary position and a one-hot mask of that bit.
module cover_lsb_pick #(
    parameter int WIDTH  = 129,
    parameter int PICK_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]  vec,
    output logic              found,
    output logic [PICK_W-1:0] index,
    output logic [WIDTH-1:0]  mask
);

    // Scan upward; the first set bit latches the index and blocks later ones.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            index = (vec[i] && !found) ? PICK_W'(i) : index;
            found = found | vec[i];
        end
    end

    // Two's-complement trick isolates the lowest set bit as a one-hot mask.
    always_comb begin
        mask = vec & (~vec + WIDTH'(1));
    end

endmodule

// File: rtl/cover_toggle_drain_sched.sv
// Toggle-coverage drain scheduler.
// Turns a wide per-cycle hit vector into a stream of first-time-hit global
// cover indices (one per cycle at most) over a valid/ready handshake, and
// keeps a sticky covered bitmap plus a saturating distinct-hit counter.
// The lowest pending index is always emitted first. Hits captured in a cycle
// only become eligible for output on the following cycle.
module cover_toggle_drain_sched
    import cover_pkg::*;
#(
    parameter int         WIDTH       = 129,
    parameter cover_idx_t COVER_INDEX = 64'd0,
    parameter int         IDX_W       = 64,
    localparam int        CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] covered_count,
    output logic             all_covered
);

    localparam int             PICK_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W:0] SAT_LIMIT  = WIDTH[CNT_W:0];
    localparam logic [CNT_W-1:0] COUNT_FULL = SAT_LIMIT[CNT_W-1:0];

    // Number of set bits in a hit vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            acc = acc + CNT_W'(v[i]);
        end
        return acc;
    endfunction

    logic [WIDTH-1:0]  covered_r;
    logic [WIDTH-1:0]  pending_r;
    slot_state_t       state_r;
    logic [IDX_W-1:0]  out_index_r;
    logic [CNT_W-1:0]  count_r;
    logic              all_covered_r;

    logic [WIDTH-1:0]  new_hits_s;
    logic              pick_found_s;
    logic [PICK_W-1:0] pick_idx_s;
    logic [WIDTH-1:0]  pick_mask_s;
    logic              load_s;
    logic              take_s;
    logic [WIDTH-1:0]  take_mask_s;
    logic [CNT_W-1:0]  hit_pop_s;
    logic [CNT_W:0]    count_sum_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [IDX_W-1:0]  pick_global_s;

    // Only the registered pending vector is searched, so same-cycle hits wait.
    cover_lsb_pick #(
        .WIDTH  (WIDTH),
        .PICK_W (PICK_W)
    ) u_pick (
        .vec   (pending_r),
        .found (pick_found_s),
        .index (pick_idx_s),
        .mask  (pick_mask_s)
    );

    // First-time hits: strobed now and not yet in the sticky bitmap.
    always_comb begin
        new_hits_s = valid & ~covered_r;
    end

    // Slot load decision; clear blocks any new load in its cycle.
    always_comb begin
        load_s        = (state_r == SLOT_EMPTY) || out_ready;
        take_s        = load_s && pick_found_s && !clear;
        pick_global_s = IDX_W'(cover_index_calc(COVER_INDEX, cover_idx_t'(pick_idx_s)));
        if (take_s) begin
            take_mask_s = pick_mask_s;
        end else begin
            take_mask_s = '0;
        end
    end

    // Distinct-hit count, saturating at WIDTH.
    always_comb begin
        hit_pop_s   = popcount(new_hits_s);
        count_sum_s = {1'b0, count_r} + {1'b0, hit_pop_s};
        if (count_sum_s > SAT_LIMIT) begin
            count_next_s = COUNT_FULL;
        end else begin
            count_next_s = count_sum_s[CNT_W-1:0];
        end
    end

    // Coverage state: sticky bitmap, pending set and the distinct-hit counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            covered_r     <= '0;
            pending_r     <= '0;
            count_r       <= '0;
            all_covered_r <= 1'b0;
        end else if (clear) begin
            covered_r     <= '0;
            pending_r     <= '0;
            count_r       <= '0;
            all_covered_r <= 1'b0;
        end else begin
            covered_r     <= covered_r | new_hits_s;
            pending_r     <= (pending_r & ~take_mask_s) | new_hits_s;
            count_r       <= count_next_s;
            all_covered_r <= (count_next_s == COUNT_FULL);
        end
    end

    // Output slot FSM: load lowest pending index, hold until handshaked.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= SLOT_EMPTY;
            out_index_r <= '0;
        end else if (clear) begin
            // A held index survives clear; only a completed handshake empties it.
            if ((state_r == SLOT_FULL) && out_ready) begin
                state_r <= SLOT_EMPTY;
            end else begin
                state_r <= state_r;
            end
        end else begin
            case (state_r)
                SLOT_EMPTY: begin
                    if (pick_found_s) begin
                        state_r     <= SLOT_FULL;
                        out_index_r <= pick_global_s;
                    end else begin
                        state_r <= SLOT_EMPTY;
                    end
                end
                SLOT_FULL: begin
                    if (out_ready && pick_found_s) begin
                        state_r     <= SLOT_FULL;
                        out_index_r <= pick_global_s;
                    end else if (out_ready) begin
                        state_r <= SLOT_EMPTY;
                    end else begin
                        state_r <= SLOT_FULL;
                    end
                end
                default: begin
                    state_r <= SLOT_EMPTY;
                end
            endcase
        end
    end

    assign out_valid     = (state_r == SLOT_FULL);
    assign out_index     = out_index_r;
    assign covered_count = count_r;
    assign all_covered   = all_covered_r;

endmodule
